stat_req_arbiter: RTL and testbench
===================================

# stat_req_arbiter

Collects statistic-update pulses from several independent sources and serialises them onto the single-request update port of the 2048-entry statistics memory. Buffers each source in a small FIFO and picks a source round-robin. Spaces output requests at least one idle cycle apart, because the memory's update port must never see `qStatUpdtReq` high on two consecutive cycles. Counts requests lost to FIFO overflow, per source.

## Interface
- `SRC_CNT`, default 4: number of request sources, range 2..8.
- `INC_LEN_BIT_WIDTH`, default 1: width of the increment field; must match the statistics memory.
- `FIFO_DEPTH`, default 4: entries per source FIFO; power of two, at least 2.
- `DROP_CNT_WIDTH`, default 16: width of each per-source drop counter.

Ports (name, direction, width, meaning):
- `Clock` in 1: clock.
- `nReset` in 1: reset; synchronous, active-low.
- `qvSrcReq` in SRC_CNT: per-source request pulse; may be high every cycle.
- `qvSrcIndex` in SRC_CNT*12: per-source counter index; source i occupies bits [12i+11:12i].
- `qvSrcNum` in SRC_CNT*INC_LEN_BIT_WIDTH: per-source increment; 0 means clear the entry, passed through unchanged.
- `qvSrcFull` out SRC_CNT: FIFO i holds FIFO_DEPTH entries (registered).
- `qDropClr` in 1: clears all drop counters.
- `qvDropCnt` out SRC_CNT*DROP_CNT_WIDTH: per-source saturating drop counters.
- `qStatUpdtReq` out 1: update request to the statistics memory; never high on two consecutive cycles.
- `qvStatUpdtReqIndex` out 12: index qualified by `qStatUpdtReq`.
- `qvStatUpdtNum` out INC_LEN_BIT_WIDTH: increment qualified by `qStatUpdtReq`.

## Operation
- **Push:** a request on source i is written to FIFO i when `qvSrcReq[i]` is high and the FIFO count is below FIFO_DEPTH.
  - Fullness is judged on the count at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- **Drop:** a request arriving while FIFO i is full is discarded and `qvDropCnt[i]` increments.
  - The counter saturates at all-ones.
- **Drop clear:**
  - `qDropClr` sets every counter to 0.
  - If `qDropClr` and a drop hit the same source in the same cycle, that counter becomes 1.
- **Arbiter states:** two-state FSM, `ARB` and `GAP`.
  - In `ARB`, if any FIFO is non-empty: grant the first non-empty source at or after pointer `rr` (wrapping at SRC_CNT), pop it, register its index/num onto the outputs with `qStatUpdtReq`=1, set `rr` to grant+1 modulo SRC_CNT, then go to `GAP`.
  - In `ARB` with all FIFOs empty: stay in `ARB`, `qStatUpdtReq`=0.
  - `GAP` always returns to `ARB` next cycle; `qStatUpdtReq`=0 and there is no pop.
- **Output hold:** index and num outputs hold their last value while `qStatUpdtReq`=0.
- **Ordering:** FIFO order is preserved within a source. There is no ordering guarantee between sources.
- **Reset values:**
  - all FIFOs empty; `qvSrcFull`=0
  - `qStatUpdtReq`=0, `qvStatUpdtReqIndex`=0, `qvStatUpdtNum`=0
  - all `qvDropCnt`=0
  - `rr`=0, state `ARB`
- **Reset mid-operation:** buffered requests are discarded without being counted as drops.

## Timing
- **Latency:** a push at edge t (source idle, arbiter in `ARB`, all other FIFOs empty) gives `qStatUpdtReq`=1 during the cycle after edge t+1, i.e. two cycles from input to output.
- **Throughput:** at most one output request per two cycles, aggregated over all sources.
- **Flags and counters:** `qvSrcFull` and `qvDropCnt` are registered and reflect the state after the current edge, one cycle after the causing event.
- **Fairness:** with all sources continuously backlogged, grants rotate 0,1,…,SRC_CNT-1 with one request every two cycles.
- **Handshake:** there is no backpressure from the statistics memory. It absorbs one request per two cycles, which matches the enforced gap.

## Structure
- **Shared package `stat_pkg`:**
  - `STAT_IDX_W`=12
  - `stat_req_t` struct {index[11:0], num}, parameterised through the package width constant
  - arbiter state enum {`ARB`, `GAP`}
- **Sub-module `stat_req_fifo`:**
  - synchronous FIFO with width 12+INC_LEN_BIT_WIDTH and depth FIFO_DEPTH
  - ports: push, pop, data in, data out, count-based full and empty
  - instantiated SRC_CNT times in a generate loop
- **Top level:** round-robin arbiter, FSM, output registers and drop counters live here.

## Test plan
- **Single request:** after reset, source 2 pulses index 0x7FF, num 1 → one `qStatUpdtReq` pulse two cycles later with index 0x7FF and num 1; `rr` becomes 3.
- **All sources together:** sources 0..3 pulse in the same cycle with indexes 0x010..0x013 → outputs 0x010, 0x011, 0x012, 0x013 on alternate cycles; `qStatUpdtReq` is never high on consecutive cycles.
- **Overflow and saturation:**
  - Source 1 requests every cycle for 20 cycles with FIFO_DEPTH=4 → `qvSrcFull[1]` asserts; drop count equals 20 minus the number accepted.
  - Force the counter to 0xFFFF → it stays at 0xFFFF.
- **Drop clear:** `qDropClr` in the same cycle as a source-0 drop → `qvDropCnt[0]`=1; other counters are 0.
- **Clear pass-through:** num=0 request on index 0x005 → output carries num 0 unchanged.
- **Reset mid-operation:** with 3 entries buffered, assert `nReset` low for one cycle → no further output request, `qvSrcFull`=0, drop counters 0, next grant starts from source 0.

Source files
------------

// File: rtl/stat_pkg.sv
// Shared types and widths for the statistics-update request path.
package stat_pkg;

  localparam int unsigned STAT_IDX_W = 12;
  // Increment width of the statistics memory as currently built.
  localparam int unsigned STAT_NUM_W = 1;

  typedef struct packed {
    logic [STAT_IDX_W-1:0] index;
    logic [STAT_NUM_W-1:0] num;
  } stat_req_t;

  typedef enum logic {
    ARB = 1'b0,
    GAP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/stat_req_fifo.sv
// Per-source request FIFO; full and empty are decoded from the registered occupancy count.
module stat_req_fifo #(
  parameter int unsigned Width = 13,
  parameter int unsigned Depth = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0]  wr_q, rd_q;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  // A pop in the same cycle never frees a slot for this cycle's push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/stat_req_arbiter.sv
// Buffers per-source statistic updates and issues them round-robin to the memory update port,
// never on two consecutive cycles; counts per-source overflow drops.
module stat_req_arbiter
  import stat_pkg::*;
#(
  parameter int unsigned SRC_CNT           = 4,
  parameter int unsigned INC_LEN_BIT_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned DROP_CNT_WIDTH    = 16
) (
  input  logic                                  Clock,
  input  logic                                  nReset,
  input  logic [SRC_CNT-1:0]                    qvSrcReq,
  input  logic [SRC_CNT*STAT_IDX_W-1:0]         qvSrcIndex,
  input  logic [SRC_CNT*INC_LEN_BIT_WIDTH-1:0]  qvSrcNum,
  output logic [SRC_CNT-1:0]                    qvSrcFull,
  input  logic                                  qDropClr,
  output logic [SRC_CNT*DROP_CNT_WIDTH-1:0]     qvDropCnt,
  output logic                                  qStatUpdtReq,
  output logic [STAT_IDX_W-1:0]                 qvStatUpdtReqIndex,
  output logic [INC_LEN_BIT_WIDTH-1:0]          qvStatUpdtNum
);

  localparam int unsigned EntryW = STAT_IDX_W + INC_LEN_BIT_WIDTH;
  localparam int unsigned SelW   = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;

  logic [SRC_CNT-1:0] fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0]  fifo_dout [SRC_CNT];

  for (genvar i = 0; i < SRC_CNT; i++) begin : g_src
    logic                      drop;
    logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;

    stat_req_fifo #(
      .Width (EntryW),
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .Clock   (Clock),
      .nReset  (nReset),
      .push_i  (qvSrcReq[i]),
      .pop_i   (fifo_pop[i]),
      .data_i  ({qvSrcIndex[i*STAT_IDX_W +: STAT_IDX_W],
                 qvSrcNum[i*INC_LEN_BIT_WIDTH +: INC_LEN_BIT_WIDTH]}),
      .data_o  (fifo_dout[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );

    assign drop = qvSrcReq[i] & fifo_full[i];

    // A clear coinciding with a drop leaves that drop counted.
    always_comb begin
      cnt_d = cnt_q;
      if (qDropClr) begin
        cnt_d = DROP_CNT_WIDTH'(drop);
      end else if (drop && (cnt_q != '1)) begin
        cnt_d = cnt_q + DROP_CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge Clock) begin
      if (!nReset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign qvDropCnt[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = cnt_q;
  end

  assign qvSrcFull = fifo_full;

  arb_state_e        state_q, state_d;
  logic [SelW-1:0]   rr_q, rr_d, grant_idx;
  logic              grant_vld;
  logic              req_q, req_d;
  logic [EntryW-1:0] entry_q, entry_d;

  // First non-empty source at or after rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < SRC_CNT; k++) begin
      logic [SelW-1:0] cand;
      cand = SelW'((32'(rr_q) + k) % SRC_CNT);
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    fifo_pop = '0;
    req_d    = 1'b0;
    entry_d  = entry_q;
    unique case (state_q)
      ARB: begin
        if (grant_vld) begin
          fifo_pop[grant_idx] = 1'b1;
          req_d               = 1'b1;
          entry_d             = fifo_dout[grant_idx];
          rr_d                = (grant_idx == SelW'(SRC_CNT - 1)) ? '0
                                                                  : grant_idx + SelW'(1);
          state_d             = GAP;
        end
      end
      GAP: state_d = ARB;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q <= ARB;
      rr_q    <= '0;
      req_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      entry_q <= entry_d;
    end
  end

  assign qStatUpdtReq       = req_q;
  assign qvStatUpdtReqIndex = entry_q[EntryW-1 -: STAT_IDX_W];
  assign qvStatUpdtNum      = entry_q[INC_LEN_BIT_WIDTH-1:0];

endmodule

// File: tb/tb_stat_req_arbiter.sv
// Directed and random stimulus for stat_req_arbiter, checked against a queue-based model.
module tb_stat_req_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned IW   = 1;
  localparam int unsigned D    = 4;
  localparam int unsigned DW   = 6;
  localparam int unsigned DMAX = (1 << DW) - 1;

  logic            Clock = 1'b0;
  logic            nReset = 1'b0;
  logic [N-1:0]    src_req = '0;
  logic [N*12-1:0] src_idx = '0;
  logic [N*IW-1:0] src_num = '0;
  logic            drop_clr = 1'b0;
  logic [N-1:0]    src_full;
  logic [N*DW-1:0] drop_cnt;
  logic            upd_req;
  logic [11:0]     upd_idx;
  logic [IW-1:0]   upd_num;

  stat_req_arbiter #(
    .SRC_CNT           (N),
    .INC_LEN_BIT_WIDTH (IW),
    .FIFO_DEPTH        (D),
    .DROP_CNT_WIDTH    (DW)
  ) dut (
    .Clock              (Clock),
    .nReset             (nReset),
    .qvSrcReq           (src_req),
    .qvSrcIndex         (src_idx),
    .qvSrcNum           (src_num),
    .qvSrcFull          (src_full),
    .qDropClr           (drop_clr),
    .qvDropCnt          (drop_cnt),
    .qStatUpdtReq       (upd_req),
    .qvStatUpdtReqIndex (upd_idx),
    .qvStatUpdtNum      (upd_num)
  );

  always #5 Clock = ~Clock;

  // Reference model: one queue per source, drop tallies, round-robin pointer.
  logic [11+IW:0] q_m [N][$];
  int             m_drop [N];
  int             m_rr;
  bit             m_req;
  bit             prev_req;
  logic [11:0]    m_idx;
  logic [IW-1:0]  m_num;
  int             n_tests = 0;
  int             n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q_m[i].delete();
      m_drop[i] = 0;
    end
    m_rr  = 0;
    m_req = 1'b0;
    m_idx = '0;
    m_num = '0;
  endtask

  task automatic step();
    int            sz [N];
    bit            dropped;
    bit            found;
    logic [11+IW:0] e;
    prev_req = upd_req;
    @(posedge Clock);
    if (!nReset) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) sz[i] = q_m[i].size();
      // A request is only issued if the previous cycle carried none.
      found = 1'b0;
      if (!m_req) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (!found && sz[j] > 0) begin
            found = 1'b1;
            e     = q_m[j].pop_front();
            m_idx = e[11+IW:IW];
            m_num = e[IW-1:0];
            m_rr  = (j + 1) % N;
          end
        end
      end
      m_req = found;
      for (int i = 0; i < N; i++) begin
        dropped = 1'b0;
        if (src_req[i]) begin
          if (sz[i] < D) q_m[i].push_back({src_idx[i*12 +: 12], src_num[i*IW +: IW]});
          else           dropped = 1'b1;
        end
        if (drop_clr)                         m_drop[i] = dropped ? 1 : 0;
        else if (dropped && m_drop[i] < DMAX) m_drop[i]++;
      end
    end
    #1;
    chk("req", upd_req, m_req);
    chk("no_back_to_back", prev_req & upd_req, 0);
    chk("idx", upd_idx, m_idx);
    chk("num", upd_num, m_num);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("full%0d", i), src_full[i], q_m[i].size() == D);
      chk($sformatf("drop%0d", i), drop_cnt[i*DW +: DW], m_drop[i]);
    end
  endtask

  task automatic set_src(input int i, input logic [11:0] idx, input logic [IW-1:0] num);
    src_req[i]          = 1'b1;
    src_idx[i*12 +: 12] = idx;
    src_num[i*IW +: IW] = num;
  endtask

  task automatic idle(input int n);
    src_req  = '0;
    drop_clr = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    model_reset();
    nReset = 1'b0;
    step();
    step();
    nReset = 1'b1;
    idle(1);

    // Single request on source 2, then 0 and 3 together: rr points at 3.
    set_src(2, 12'h7FF, 1'b1);
    step();
    idle(4);
    set_src(0, 12'h100, 1'b1);
    set_src(3, 12'h103, 1'b0);
    step();
    src_req = '0;
    step();
    step();
    chk("rr_after_src2", upd_idx, 12'h103);
    idle(4);

    // All sources in the same cycle.
    for (int i = 0; i < N; i++) set_src(i, 12'h010 + 12'(i), 1'b1);
    step();
    idle(10);

    // Overflow on source 1.
    for (int c = 0; c < 20; c++) begin
      set_src(1, 12'h200 + 12'(c), c[0]);
      step();
    end
    idle(12);

    // Saturation on source 1.
    for (int c = 0; c < 200; c++) begin
      set_src(1, 12'h300 + 12'(c), 1'b1);
      step();
    end
    idle(12);
    chk("sat_drop1", drop_cnt[DW +: DW], DMAX);

    // Clear coinciding with a source-0 drop.
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    guard = 0;
    while (q_m[0].size() != D && guard < 50) begin
      set_src(0, 12'h400 + 12'(guard), 1'b1);
      step();
      guard++;
    end
    chk("fill_src0", src_full[0], 1'b1);
    set_src(0, 12'h4FF, 1'b1);
    drop_clr = 1'b1;
    step();
    chk("clr_drop0", drop_cnt[0 +: DW], 1);
    chk("clr_drop1", drop_cnt[DW +: DW], 0);
    idle(12);

    // Clear-entry pass-through (num = 0).
    set_src(1, 12'h005, 1'b0);
    step();
    idle(4);
    chk("num0_idx", upd_idx, 12'h005);
    chk("num0_num", upd_num, 0);

    // Reset with three entries buffered; rr is 2 beforehand.
    set_src(0, 12'h600, 1'b1);
    set_src(1, 12'h601, 1'b1);
    set_src(2, 12'h602, 1'b1);
    step();
    src_req = '0;
    nReset  = 1'b0;
    step();
    nReset  = 1'b1;
    idle(4);
    chk("rst_full", src_full, 0);
    chk("rst_drop", drop_cnt, 0);
    set_src(0, 12'h700, 1'b1);
    set_src(3, 12'h703, 1'b1);
    step();
    src_req = '0;
    step();
    chk("rst_first_grant", upd_idx, 12'h700);
    idle(4);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      src_req  = N'($urandom & $urandom);
      src_idx  = {$urandom, $urandom};
      src_num  = N'($urandom);
      drop_clr = ($urandom_range(0, 24) == 0);
      step();
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
